// File: rtl/spi_reg_bridge.sv
// Command/register layer behind the byte-level SPI slave: decodes read/write frames
// with address auto-increment and returns read data or status bytes for MISO.
module spi_reg_bridge #(
  parameter int         ADDR_W      = 7,
  parameter logic [7:0] STATUS_BYTE = 8'hA5,
  parameter logic [7:0] ERR_BYTE    = 8'hEE,
  parameter int         RD_TIMEOUT  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ss_n,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic              o_reg_wr_en,
  output logic [7:0]        o_reg_wdata,
  output logic              o_reg_rd_en,
  input  logic [7:0]        i_reg_rdata,
  input  logic              i_reg_rd_valid,
  output logic              o_busy,
  output logic              o_err_timeout,
  output logic              o_err_overrun,
  input  logic              i_err_clr
);

  localparam int CNT_W = $clog2(RD_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, WR_DATA, RD_WAIT, RD_STREAM} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  addr, addr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               ss_meta, ss_sync, ss_dly;
  logic               frame_end;
  logic [ADDR_W-1:0]  reg_addr_n;
  logic               wr_en_n, rd_en_n, tx_valid_n;
  logic [7:0]         wdata_n, tx_data_n;
  logic               tmo_n, ovr_n;

  assign frame_end = ss_sync & ~ss_dly;
  assign o_busy    = ~ss_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ss_meta       <= 1'b1;
      ss_sync       <= 1'b1;
      ss_dly        <= 1'b1;
      state         <= IDLE;
      addr          <= '0;
      cnt           <= '0;
      o_reg_addr    <= '0;
      o_reg_wr_en   <= 1'b0;
      o_reg_wdata   <= '0;
      o_reg_rd_en   <= 1'b0;
      o_tx_valid    <= 1'b0;
      o_tx_data     <= '0;
      o_err_timeout <= 1'b0;
      o_err_overrun <= 1'b0;
    end else begin
      ss_meta       <= i_ss_n;
      ss_sync       <= ss_meta;
      ss_dly        <= ss_sync;
      state         <= state_n;
      addr          <= addr_n;
      cnt           <= cnt_n;
      o_reg_addr    <= reg_addr_n;
      o_reg_wr_en   <= wr_en_n;
      o_reg_wdata   <= wdata_n;
      o_reg_rd_en   <= rd_en_n;
      o_tx_valid    <= tx_valid_n;
      o_tx_data     <= tx_data_n;
      o_err_timeout <= tmo_n;
      o_err_overrun <= ovr_n;
    end
  end

  // Frame end overrides everything else; a late read response after it is simply not looked at.
  always_comb begin
    state_n    = state;
    addr_n     = addr;
    cnt_n      = cnt;
    reg_addr_n = o_reg_addr;
    wr_en_n    = 1'b0;
    wdata_n    = o_reg_wdata;
    rd_en_n    = 1'b0;
    tx_valid_n = 1'b0;
    tx_data_n  = o_tx_data;
    tmo_n      = o_err_timeout;
    ovr_n      = o_err_overrun;

    if (frame_end) begin
      state_n    = IDLE;
      tx_valid_n = 1'b1;
      tx_data_n  = STATUS_BYTE;
    end else begin
      case (state)
        IDLE: begin
          if (i_rx_valid) begin
            addr_n = i_rx_data[ADDR_W-1:0];
            if (i_rx_data[7]) begin
              rd_en_n    = 1'b1;
              reg_addr_n = i_rx_data[ADDR_W-1:0];
              cnt_n      = '0;
              state_n    = RD_WAIT;
            end else begin
              state_n = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (i_rx_valid) begin
            wr_en_n    = 1'b1;
            wdata_n    = i_rx_data;
            reg_addr_n = addr;
            addr_n     = addr + 1'b1;
          end
        end
        RD_WAIT: begin
          if (i_rx_valid) ovr_n = 1'b1;
          if (i_reg_rd_valid) begin
            tx_valid_n = 1'b1;
            tx_data_n  = i_reg_rdata;
            state_n    = RD_STREAM;
          end else if (cnt == CNT_W'(RD_TIMEOUT - 1)) begin
            tx_valid_n = 1'b1;
            tx_data_n  = ERR_BYTE;
            tmo_n      = 1'b1;
            state_n    = RD_STREAM;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        RD_STREAM: begin
          if (i_rx_valid) begin
            addr_n     = addr + 1'b1;
            reg_addr_n = addr + 1'b1;
            rd_en_n    = 1'b1;
            cnt_n      = '0;
            state_n    = RD_WAIT;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (i_err_clr) begin
      tmo_n = 1'b0;
      ovr_n = 1'b0;
    end
  end

endmodule
